// File: rtl/sys_pll_rst_seq.sv
// Lock supervisor and reset sequencer for the system PLL, clocked by the PLL reference clock.
// Qualifies extlock, releases domain resets in order, and re-resets the PLL on lock timeout.
module sys_pll_rst_seq #(
  parameter int NUM_DOM        = 3,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65535,
  parameter int LOCK_STABLE    = 1024,
  parameter int STAGE_GAP      = 8,
  parameter int MAX_RETRY      = 7
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               extlock,
  input  logic               soft_rst_req,
  output logic               pll_rst,
  output logic [NUM_DOM-1:0] dom_rst_n,
  output logic               sys_ready,
  output logic [3:0]         retry_cnt,
  output logic               pll_fail
);

  typedef enum logic [2:0] {
    ST_PLL_RST,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RELEASE,
    ST_RUN,
    ST_FAIL
  } state_e;

  localparam logic [15:0]        RST_LAST  = 16'(PLL_RST_CYCLES - 1);
  localparam logic [15:0]        TMO_LAST  = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0]        STB_LAST  = 16'(LOCK_STABLE - 1);
  localparam logic [15:0]        GAP_LAST  = 16'(STAGE_GAP - 1);
  localparam logic [3:0]         RETRY_MAX = 4'(MAX_RETRY);
  localparam logic [NUM_DOM-1:0] DOM_ONE   = NUM_DOM'(1);
  localparam logic [NUM_DOM-1:0] DOM_ALL   = '1;

  state_e             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [3:0]         retry_q, retry_d;
  logic               pll_rst_q, pll_rst_d;
  logic [NUM_DOM-1:0] dom_q, dom_d;
  logic               ready_q, ready_d;
  logic               fail_q, fail_d;
  logic [1:0]         sync_q;
  logic               lock_s;

  assign lock_s = sync_q[1];

  // One shared counter serves as reset-hold count, lock timer, stable count and stage gap.
  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path leaves one unassigned and infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    pll_rst_d = pll_rst_q;
    dom_d     = dom_q;
    ready_d   = ready_q;
    fail_d    = fail_q;

    if (soft_rst_req) begin
      state_d   = ST_PLL_RST;
      cnt_d     = '0;
      retry_d   = '0;
      fail_d    = 1'b0;
      pll_rst_d = 1'b1;
      dom_d     = '0;
      ready_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_PLL_RST: begin
          pll_rst_d = 1'b1;
          dom_d     = '0;
          ready_d   = 1'b0;
          if (cnt_q == RST_LAST) begin
            state_d   = ST_WAIT_LOCK;
            cnt_d     = '0;
            pll_rst_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TMO_LAST) begin
            cnt_d     = '0;
            pll_rst_d = 1'b1;
            if (retry_q == RETRY_MAX) begin
              state_d = ST_FAIL;
              fail_d  = 1'b1;
            end else begin
              state_d = ST_PLL_RST;
              retry_d = retry_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STB_LAST) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
            dom_d   = DOM_ONE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_RELEASE, ST_RUN: begin
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
            dom_d   = '0;
            ready_d = 1'b0;
          end else if (state_q == ST_RELEASE) begin
            if (dom_q == DOM_ALL) begin
              state_d = ST_RUN;
              ready_d = 1'b1;
            end else if (cnt_q == GAP_LAST) begin
              dom_d = (dom_q << 1) | DOM_ONE;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end
        end
        ST_FAIL: begin
          pll_rst_d = 1'b1;
          fail_d    = 1'b1;
          dom_d     = '0;
          ready_d   = 1'b0;
        end
        default: state_d = ST_PLL_RST;
      endcase
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_PLL_RST;
      cnt_q     <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      dom_q     <= '0;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
      sync_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, keeping the synchroniser two stages deep.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      dom_q     <= dom_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
      sync_q    <= {sync_q[0], extlock};
    end
  end

  assign pll_rst   = pll_rst_q;
  assign dom_rst_n = dom_q;
  assign sys_ready = ready_q;
  assign retry_cnt = retry_q;
  assign pll_fail  = fail_q;

endmodule

// File: tb/tb_sys_pll_rst_seq.sv
// Directed bench for sys_pll_rst_seq with short sim parameters; status vector is
// {pll_rst, dom_rst_n[2:0], sys_ready, retry_cnt[3:0], pll_fail}.
module tb_sys_pll_rst_seq;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       extlock;
  logic       soft_rst_req;
  logic       pll_rst;
  logic [2:0] dom_rst_n;
  logic       sys_ready;
  logic [3:0] retry_cnt;
  logic       pll_fail;
  logic [9:0] st;

  int n_vec = 0;
  int n_bad = 0;

  always #20 refclk = ~refclk;

  assign st = {pll_rst, dom_rst_n, sys_ready, retry_cnt, pll_fail};

  sys_pll_rst_seq #(
    .NUM_DOM(3), .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(64),
    .LOCK_STABLE(8), .STAGE_GAP(2), .MAX_RETRY(2)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .extlock(extlock), .soft_rst_req(soft_rst_req),
    .pll_rst(pll_rst), .dom_rst_n(dom_rst_n), .sys_ready(sys_ready),
    .retry_cnt(retry_cnt), .pll_fail(pll_fail)
  );

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    extlock      = 1'b0;
    soft_rst_req = 1'b0;
    tick();
    tick();
    n_vec++;
    if (st !== 10'b1_000_0_0000_0) begin
      n_bad++;
      $display("FAIL reset_state: got %b want %b", st, 10'b1_000_0_0000_0);
    end
    rst_n = 1'b1;
  endtask

  // Edge k counts refclk edges after rst_n release; extlock rises after edge 10.
  task automatic test_nominal();
    int         ck_k[9] = '{3, 4, 20, 21, 22, 23, 24, 25, 26};
    logic [9:0] ck_v[9] = '{10'b1_000_0_0000_0, 10'b0_000_0_0000_0, 10'b0_000_0_0000_0,
                            10'b0_001_0_0000_0, 10'b0_001_0_0000_0, 10'b0_011_0_0000_0,
                            10'b0_011_0_0000_0, 10'b0_111_0_0000_0, 10'b0_111_1_0000_0};
    int j = 0;
    for (int k = 1; k <= 26; k++) begin
      tick();
      if (k == 10) extlock = 1'b1;
      if (j < 9 && ck_k[j] == k) begin
        n_vec++;
        if (st !== ck_v[j]) begin
          n_bad++;
          $display("FAIL nominal edge %0d: got %b want %b", k, st, ck_v[j]);
        end
        j++;
      end
    end
  endtask

  // extlock high after edge 10, low after 15, high again after 16.
  task automatic test_glitchy_lock();
    int         ck_k[6] = '{18, 21, 26, 27, 31, 32};
    logic [9:0] ck_v[6] = '{10'b0_000_0_0000_0, 10'b0_000_0_0000_0, 10'b0_000_0_0000_0,
                            10'b0_001_0_0000_0, 10'b0_111_0_0000_0, 10'b0_111_1_0000_0};
    int j = 0;
    rst_n   = 1'b0;
    extlock = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k == 10) extlock = 1'b1;
      if (k == 15) extlock = 1'b0;
      if (k == 16) extlock = 1'b1;
      if (j < 6 && ck_k[j] == k) begin
        n_vec++;
        if (st !== ck_v[j]) begin
          n_bad++;
          $display("FAIL glitchy_lock edge %0d: got %b want %b", k, st, ck_v[j]);
        end
        j++;
      end
    end
  endtask

  // Starts in RUN; extlock drops after edge 2 and returns after edge 8.
  task automatic test_lock_loss();
    int         ck_k[8] = '{4, 5, 6, 18, 19, 21, 23, 24};
    logic [9:0] ck_v[8] = '{10'b0_111_1_0000_0, 10'b0_000_0_0000_0, 10'b0_000_0_0000_0,
                            10'b0_000_0_0000_0, 10'b0_001_0_0000_0, 10'b0_011_0_0000_0,
                            10'b0_111_0_0000_0, 10'b0_111_1_0000_0};
    int j = 0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k == 2) extlock = 1'b0;
      if (k == 8) extlock = 1'b1;
      if (j < 8 && ck_k[j] == k) begin
        n_vec++;
        if (st !== ck_v[j]) begin
          n_bad++;
          $display("FAIL lock_loss edge %0d: got %b want %b", k, st, ck_v[j]);
        end
        j++;
      end
    end
  endtask

  // Starts in RUN; extlock held low. Lock loss at edge 3, then 64-edge timeouts.
  task automatic test_timeout_fail();
    int         ck_k[12] = '{3, 66, 67, 70, 71, 134, 135, 138, 139, 202, 203, 220};
    logic [9:0] ck_v[12] = '{10'b0_000_0_0000_0, 10'b0_000_0_0000_0, 10'b1_000_0_0001_0,
                             10'b1_000_0_0001_0, 10'b0_000_0_0001_0, 10'b0_000_0_0001_0,
                             10'b1_000_0_0010_0, 10'b1_000_0_0010_0, 10'b0_000_0_0010_0,
                             10'b0_000_0_0010_0, 10'b1_000_0_0010_1, 10'b1_000_0_0010_1};
    int j = 0;
    extlock = 1'b0;
    for (int k = 1; k <= 220; k++) begin
      tick();
      if (j < 12 && ck_k[j] == k) begin
        n_vec++;
        if (st !== ck_v[j]) begin
          n_bad++;
          $display("FAIL timeout_fail edge %0d: got %b want %b", k, st, ck_v[j]);
        end
        j++;
      end
    end
  endtask

  // Starts in FAIL; extlock rises at once, soft_rst_req is sampled at edge 6.
  task automatic test_recovery();
    int         ck_k[9] = '{5, 6, 9, 10, 18, 19, 21, 23, 24};
    logic [9:0] ck_v[9] = '{10'b1_000_0_0010_1, 10'b1_000_0_0000_0, 10'b1_000_0_0000_0,
                            10'b0_000_0_0000_0, 10'b0_000_0_0000_0, 10'b0_001_0_0000_0,
                            10'b0_011_0_0000_0, 10'b0_111_0_0000_0, 10'b0_111_1_0000_0};
    int j = 0;
    extlock = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k == 5) soft_rst_req = 1'b1;
      if (k == 6) soft_rst_req = 1'b0;
      if (j < 9 && ck_k[j] == k) begin
        n_vec++;
        if (st !== ck_v[j]) begin
          n_bad++;
          $display("FAIL recovery edge %0d: got %b want %b", k, st, ck_v[j]);
        end
        j++;
      end
    end
  endtask

  // Soft restart from RUN, reach dom_rst_n=011, then pull rst_n mid-cycle.
  task automatic test_async_reset();
    soft_rst_req = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 1) soft_rst_req = 1'b0;
      if (k == 15 || k == 16) begin
        n_vec++;
        if (st !== ((k == 15) ? 10'b0_001_0_0000_0 : 10'b0_011_0_0000_0)) begin
          n_bad++;
          $display("FAIL async_pre edge %0d: got %b want %b", k, st,
                   (k == 15) ? 10'b0_001_0_0000_0 : 10'b0_011_0_0000_0);
        end
      end
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (st !== 10'b1_000_0_0000_0) begin
      n_bad++;
      $display("FAIL async_reset_immediate: got %b want %b", st, 10'b1_000_0_0000_0);
    end
    tick();
    n_vec++;
    if (st !== 10'b1_000_0_0000_0) begin
      n_bad++;
      $display("FAIL async_reset_held: got %b want %b", st, 10'b1_000_0_0000_0);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k >= 3) begin
        n_vec++;
        if (pll_rst !== (k == 3)) begin
          n_bad++;
          $display("FAIL async_restart_pll_rst edge %0d: got %b want %b", k, pll_rst, (k == 3));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_glitchy_lock();
    test_lock_loss();
    test_timeout_fail();
    test_recovery();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
